// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, keeps at most one request in flight
// to instruction memory and drives the IF/ID latch into decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_con_ifstall,
  input  logic [1:0]  i_con_jump,
  input  logic [31:0] i_addr_jump,
  input  logic [31:0] i_data_jr,
  input  logic        i_con_Ebranch,
  input  logic [31:0] i_addr_Ebranch,
  output logic [31:0] o_addr_pc4,
  output logic [31:0] o_data_instr,
  output logic        o_con_Dvalid,
  output logic        o_con_Dflush
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, buf_q, buf_d;
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
  logic        dvalid_q, dvalid_d;

  logic [31:0] br_tgt, jmp_tgt, pc_inc;
  logic        jump, bubble;

  assign br_tgt  = i_addr_Ebranch & ~32'd3;
  assign jmp_tgt = (i_con_jump == 2'b01) ? (i_addr_jump & ~32'd3) : (i_data_jr & ~32'd3);
  assign jump    = ((i_con_jump == 2'b01) || (i_con_jump == 2'b10)) && !i_con_ifstall && dvalid_q;
  assign pc_inc  = pc_q + 32'd4;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    buf_d    = buf_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    dvalid_d = dvalid_q;
    bubble   = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        addr_d  = pc_q;
      end
      S_REQ: begin
        if (i_con_Ebranch || (jump && !i_con_ifstall)) begin
          // A redirect without ack leaves the old request in flight; KILL eats its response.
          pc_d   = i_con_Ebranch ? br_tgt : jmp_tgt;
          bubble = 1'b1;
          if (i_imem_ack) addr_d  = pc_d;
          else            state_d = S_KILL;
        end else if (i_con_ifstall) begin
          if (i_imem_ack) begin
            buf_d   = i_imem_rdata;
            state_d = S_HOLD;
          end
        end else if (i_imem_ack) begin
          instr_d  = i_imem_rdata;
          pc4_d    = pc_inc;
          dvalid_d = 1'b1;
          pc_d     = pc_inc;
          addr_d   = pc_inc;
        end else begin
          bubble = 1'b1;
        end
      end
      S_KILL: begin
        bubble = 1'b1;
        if (i_con_Ebranch) pc_d = br_tgt;
        if (i_imem_ack) begin
          state_d = S_REQ;
          addr_d  = pc_d;
        end
      end
      default: begin
        if (i_con_Ebranch || jump) begin
          pc_d    = i_con_Ebranch ? br_tgt : jmp_tgt;
          bubble  = 1'b1;
          state_d = S_REQ;
          addr_d  = pc_d;
        end else if (!i_con_ifstall) begin
          instr_d  = buf_q;
          pc4_d    = pc_inc;
          dvalid_d = 1'b1;
          pc_d     = pc_inc;
          addr_d   = pc_inc;
          state_d  = S_REQ;
        end
      end
    endcase
    if (bubble) begin
      instr_d  = NOP_INSTR;
      pc4_d    = 32'd0;
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      buf_q    <= 32'd0;
      instr_q  <= NOP_INSTR;
      pc4_q    <= 32'd0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      buf_q    <= buf_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign o_imem_req   = (state_q == S_REQ) || (state_q == S_KILL);
  assign o_imem_addr  = addr_q;
  assign o_addr_pc4   = pc4_q;
  assign o_data_instr = instr_q;
  assign o_con_Dvalid = dvalid_q;
  assign o_con_Dflush = i_con_Ebranch;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, issues single-outstanding requests to instruction memory, and drives the IF/ID interface (instruction, PC+4) into the decode stage.
- Consumes the decode-stage PC feedback: stall, jump select, jump target and jr register value.
- Consumes the execute-stage resolved branch, and exports a flush pulse to the hazard unit.
- No delay slots: every redirect squashes wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected as a bubble (sll $0,$0,0).

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  reset
- o_imem_req  out  1  fetch request; held high until i_imem_ack
- o_imem_addr  out  32  word address of the outstanding request; [1:0] always 0
- i_imem_ack  in  1  response valid; sampled at the rising edge while o_imem_req=1
- i_imem_rdata  in  32  instruction word, valid with ack
- i_con_ifstall  in  1  decode stall: hold the IF/ID contents
- i_con_jump  in  2  00 none, 01 j/jal (i_addr_jump), 10 jr (i_data_jr), 11 none
- i_addr_jump  in  32  j/jal target
- i_data_jr  in  32  jr target
- i_con_Ebranch  in  1  execute stage: branch taken
- i_addr_Ebranch  in  32  branch target
- o_addr_pc4  out  32  IF/ID PC+4
- o_data_instr  out  32  IF/ID instruction
- o_con_Dvalid  out  1  IF/ID holds a real instruction
- o_con_Dflush  out  1  combinational, equal to i_con_Ebranch; hazard unit squashes the D/E latch

Behaviour:
- Reset is i_nrst, asynchronous, active-low; clock is i_clk.
- Reset values:
  - PC=RESET_PC, request address=RESET_PC.
  - o_imem_req=0, o_addr_pc4=0, o_data_instr=NOP_INSTR, o_con_Dvalid=0.
  - Hold buffer empty; state IDLE.
- All redirect targets are masked to [1:0]=00.
- i_con_jump is ignored while o_con_Dvalid=0.
- A "jump" below means i_con_jump is 01 or 10, with i_con_ifstall=0 and o_con_Dvalid=1.
- Redirect priority: i_con_Ebranch > i_con_ifstall > jump > sequential.
- A "bubble" means IF/ID <= {NOP_INSTR, 0}, o_con_Dvalid=0.
- o_imem_addr is a registered copy of the request address and is stable while o_imem_req=1.
- o_imem_req=1 in states REQ and KILL, 0 otherwise.
- FSM states:
  - IDLE: entered on reset. Next edge goes to REQ with request address = PC.
  - REQ: request for PC outstanding. At each edge:
    - Ebranch: PC <= target, bubble. If ack, stay REQ (new address); else go to KILL.
    - else stall: IF/ID held. If ack, buffer <= rdata and go to HOLD; else stay REQ.
    - else jump: PC <= target, bubble, response discarded. If ack, stay REQ; else go to KILL.
    - else ack: IF/ID <= {rdata, PC+4}, Dvalid=1, PC <= PC+4, next request at PC+4.
    - else (no ack): bubble, stay REQ.
  - KILL: the stale request is still outstanding; its response will be discarded.
    - IF/ID is a bubble.
    - Ebranch updates PC and keeps the state.
    - Ack returns to REQ with request address = current PC.
  - HOLD: instruction for PC is buffered; no request outstanding.
    - Ebranch: drop buffer, PC <= target, bubble, go to REQ.
    - stall: hold everything.
    - jump: drop buffer, PC <= target, bubble, go to REQ.
    - else: IF/ID <= {buffer, PC+4}, Dvalid=1, PC <= PC+4, go to REQ.
- Zero-wait memory (ack in the same cycle as req) sustains 1 instruction/cycle.
- Redirect latency: the target's instruction reaches IF/ID no earlier than 1 edge after its request issues.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- Reset mid-request: the response is dropped; memory must tolerate request withdrawal.

Test Plan:
- Reset, zero-wait ack, rdata=addr|0x1000_0000 → IF/ID sequence: {0x1000_0000, pc4=4}, {0x1000_0004, pc4=8}, …; Dvalid=1 from the 2nd edge after reset release.
- Ack delayed 2 cycles per request → exactly 2 bubbles (Dvalid=0, instr=0) between instructions; o_imem_addr stable while waiting.
- Stall raised while ack arrives at addr 0x8 → IF/ID holds the 0x4 instruction, state HOLD, req=0. Stall drops → addr 0x8 instruction presented with pc4=0xC, then a request to 0xC.
- IF/ID valid, jump=01, i_addr_jump=0x40 → next request addr 0x40, one bubble. Same with jump=10, i_data_jr=0x83 → request 0x80.
- Ebranch=1 to 0x200 while a request to 0x10 is unacked → Dflush=1 that cycle, state KILL. The late ack for 0x10 is discarded; the next request is 0x200.
- Ebranch concurrent with stall and jump=01 → branch target 0x300 wins; bubble inserted despite the stall.
